move_cmd_gen: RTL and testbench

- Input front-end for the 2048 game controller. It turns four raw, bouncing push-buttons into clean move commands: one at a time, one-hot, and held until accepted.
- Sits between the board's direction buttons and the game FSM. It is the initiator of the move protocol that the game FSM consumes through its up/down/left/right inputs.
- Guarantees one command per physical press, no auto-repeat, and the same direction priority the game FSM applies.

---
 rtl/move_cmd_gen.sv | 129 ++++++++++++
 tb/tb_move_cmd_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/move_cmd_gen.sv
// Button front-end for the 2048 controller: synchronises and debounces four
// direction buttons and issues one prioritised, held move command per press.
module move_cmd_gen #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       move_ack,
   output logic       move_valid,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic [3:0] btn_level
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PEND, RELEASE} state_t;

   logic [3:0]       raw;
   logic [3:0]       sync_p0;
   logic [3:0]       sync_p1;
   logic [3:0]       deb;
   logic [3:0]       deb_q;
   logic [CNT_W-1:0] cnt [4];
   logic [3:0]       press;
   logic [3:0]       pick;
   logic [3:0]       dir;
   logic [3:0]       dir_nxt;
   state_t           state;
   state_t           state_nxt;

   // Bit order {right,left,down,up}: the highest set bit has the highest priority.
   function automatic logic [3:0] pick_one(input logic [3:0] p);
      logic [3:0] r;
      r = 4'b0000;
      if (p[3])      r = 4'b1000;
      else if (p[2]) r = 4'b0100;
      else if (p[1]) r = 4'b0010;
      else if (p[0]) r = 4'b0001;
      return r;
   endfunction

   assign raw = {btn_right, btn_left, btn_down, btn_up};

   // Stage: two-flop synchroniser
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   // Stage: debounce; any agreeing cycle restarts the stability count
   always_ff @(posedge Clk) begin
      if (Reset) begin
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         deb_q <= deb;
         for (int i = 0; i < 4; i++) begin
            if (sync_p1[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync_p1[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign press = deb & ~deb_q;
   assign pick  = pick_one(press);

   // Stage: command handshake
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         dir   <= '0;
      end else begin
         state <= state_nxt;
         dir   <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      case (state)
         IDLE: begin
            if (|press) begin
               dir_nxt   = pick;
               state_nxt = PEND;
            end
         end
         PEND: begin
            if (move_ack) begin
               dir_nxt   = '0;
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            // Wait for every button to be released so a held key never repeats.
            if (deb == 4'b0000) state_nxt = IDLE;
         end
         default: begin
            dir_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign {right, left, down, up} = dir;
   assign move_valid = |dir;
   assign btn_level  = deb;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Bench for move_cmd_gen with a short debounce window: directed table,
// hand-written corner sequences and random buttons against a reference model.
module tb_move_cmd_gen;

   localparam int D = 4;

   logic       Clk = 1'b0;
   logic       rst = 1'b1;
   logic       ack = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic       move_valid, up, down, left, right;
   logic [3:0] btn_level;

   int checks = 0;
   int errors = 0;

   move_cmd_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .Clk       (Clk),
      .Reset     (rst),
      .btn_up    (btn[0]),
      .btn_down  (btn[1]),
      .btn_left  (btn[2]),
      .btn_right (btn[3]),
      .move_ack  (ack),
      .move_valid(move_valid),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .btn_level (btn_level)
   );

   always #5 Clk = ~Clk;

   // Reference model: level flips once the synchronised input has disagreed with
   // it for the last D edges, with at least D edges since the previous flip.
   logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvl_prev = '0;
   logic [3:0] m_hist[$];
   int         m_since[4] = '{D, D, D, D};
   int         m_pend = -1;
   bit         m_wait = 1'b0;

   task automatic model_edge();
      logic [3:0] pr;
      logic [3:0] h;
      bit         all;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0;
         m_hist.delete();
         for (int b = 0; b < 4; b++) m_since[b] = D;
         m_pend = -1;
         m_wait = 1'b0;
         return;
      end
      pr = m_lvl & ~m_lvl_prev;
      if (m_pend < 0 && !m_wait) begin
         for (int b = 0; b < 4; b++) if (pr[b]) m_pend = b;
      end else if (m_pend >= 0) begin
         if (ack) begin
            m_pend = -1;
            m_wait = 1'b1;
         end
      end else if (m_lvl == 4'b0000) begin
         m_wait = 1'b0;
      end
      m_lvl_prev = m_lvl;
      m_hist.push_front(m_s2);
      if (m_hist.size() > D) void'(m_hist.pop_back());
      for (int b = 0; b < 4; b++) begin
         m_since[b]++;
         if (m_hist.size() == D && m_since[b] >= D) begin
            all = 1'b1;
            for (int i = 0; i < D; i++) begin
               h = m_hist[i];
               if (h[b] == m_lvl[b]) all = 1'b0;
            end
            if (all) begin
               m_lvl[b]   = ~m_lvl[b];
               m_since[b] = 0;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = btn;
   endtask

   function automatic logic [8:0] dut_vec();
      return {move_valid, right, left, down, up, btn_level};
   endfunction

   function automatic logic [8:0] model_vec();
      logic [3:0] d;
      d = 4'b0000;
      if (m_pend >= 0) d[m_pend] = 1'b1;
      return {(m_pend >= 0), d, m_lvl};
   endfunction

   task automatic check_eq(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      logic [3:0] d;
      @(posedge Clk);
      model_edge();
      #1;
      check_eq("model", int'(dut_vec()), int'(model_vec()));
      d = {right, left, down, up};
      check_eq("invariant", int'({($countones(d) <= 1), (move_valid == |d)}), 3);
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] btn;
      logic       ack;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[17];
   int   n_a, n_b, first;

   initial begin
      // Reset with all buttons held, then right wins after D+2 edges.
      for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 4'hF, 1'b0, 9'h000};
      for (int i = 3; i < 8; i++) vecs[i] = '{1'b0, 4'hF, 1'b0, 9'h000};
      vecs[8]  = '{1'b0, 4'hF, 1'b0, 9'h00F};
      vecs[9]  = '{1'b0, 4'hF, 1'b0, 9'h18F};
      vecs[10] = '{1'b0, 4'hF, 1'b1, 9'h00F};
      for (int i = 11; i < 16; i++) vecs[i] = '{1'b0, 4'h0, 1'b0, 9'h00F};
      vecs[16] = '{1'b0, 4'h0, 1'b0, 9'h000};

      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst;
         btn = vecs[i].btn;
         ack = vecs[i].ack;
         tick();
         check_eq($sformatf("vec%0d", i), int'(dut_vec()), int'(vecs[i].exp));
      end
      for (int i = 0; i < 3; i++) tick();

      // Clean up press with ack tied high: one pulse, no repeat while held.
      btn = 4'b0001; ack = 1'b1; n_a = 0; first = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (up) begin n_a++; if (first == 0) first = i; end
      end
      check_eq("up_pulses", n_a, 1);
      check_eq("up_latency", first, 7);
      btn = 4'b0000; ack = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_eq("up_level_held", int'(btn_level[0]), 1);
      tick();
      check_eq("up_level_fall", int'(btn_level[0]), 0);
      for (int i = 0; i < 4; i++) tick();

      // Bouncing left must not trigger; the stable period gives one pulse.
      ack = 1'b1; n_a = 0;
      for (int i = 0; i < 12; i++) begin
         btn = ((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
         tick();
         if (left) n_a++;
      end
      check_eq("bounce_pulses", n_a, 0);
      btn = 4'b0100; n_a = 0; first = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (left) begin n_a++; if (first == 0) first = i; end
      end
      check_eq("left_pulses", n_a, 1);
      check_eq("left_latency", first, 7);
      btn = 4'b0000; ack = 1'b0;
      for (int i = 0; i < 10; i++) tick();

      // Simultaneous up and right: right only; later up works.
      btn = 4'b1001; ack = 1'b1; n_a = 0; n_b = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (right) n_a++;
         if (up) n_b++;
      end
      check_eq("prio_right", n_a, 1);
      check_eq("prio_up", n_b, 0);
      btn = 4'b0000;
      for (int i = 0; i < 10; i++) tick();
      btn = 4'b0001; n_b = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (up) n_b++; end
      check_eq("up_after_prio", n_b, 1);
      btn = 4'b0000; ack = 1'b0;
      for (int i = 0; i < 10; i++) tick();

      // Down held pending without ack; right pressed meanwhile is ignored.
      btn = 4'b0010; ack = 1'b0;
      for (int i = 0; i < 20 && !move_valid; i++) tick();
      check_eq("down_valid", int'(move_valid), 1);
      n_a = 0; n_b = 0;
      for (int i = 0; i < 10; i++) begin
         btn = (i >= 3) ? 4'b1010 : 4'b0010;
         tick();
         if (down) n_a++;
         if (right) n_b++;
      end
      check_eq("down_held", n_a, 10);
      check_eq("right_in_pend", n_b, 0);
      ack = 1'b1;
      tick();
      check_eq("down_cleared", int'(dut_vec()[8:4]), 0);
      ack = 1'b0; n_b = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (right) n_b++; end
      check_eq("right_held_ignored", n_b, 0);
      btn = 4'b0000;
      for (int i = 0; i < 12; i++) tick();
      btn = 4'b1000; ack = 1'b1; n_b = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (right) n_b++; end
      check_eq("right_repress", n_b, 1);
      btn = 4'b0000; ack = 1'b0;
      for (int i = 0; i < 10; i++) tick();

      // Reset while pending with left still held.
      btn = 4'b0100; ack = 1'b0;
      for (int i = 0; i < 20 && !move_valid; i++) tick();
      check_eq("left_pend", int'(left), 1);
      rst = 1'b1;
      tick();
      check_eq("reset_clear", int'(dut_vec()), 0);
      rst = 1'b0; first = 0;
      for (int i = 1; i <= 12 && first == 0; i++) begin
         tick();
         if (left) first = i;
      end
      check_eq("left_after_reset", first, 7);
      ack = 1'b1;
      tick();
      btn = 4'b0000; ack = 1'b0;
      for (int i = 0; i < 10; i++) tick();

      // Random buttons, ack and occasional reset against the model.
      for (int seg = 0; seg < 300; seg++) begin
         n_a = $urandom_range(1, 14);
         btn = 4'($urandom);
         if ($urandom_range(0, 2) == 0) btn = 4'b0000;
         for (int c = 0; c < n_a; c++) begin
            ack = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
         end
      end
      rst = 1'b0;
      btn = 4'b0000;
      for (int i = 0; i < 10; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
